// File: rtl/param_univ_shift_register.sv
// Universal shift register with single-step ops and a counted multi-step burst mode.
// Single-step ops update Q on the same enabled edge; a burst of N steps completes over N edges and then pulses done.
module param_univ_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] data,
   input  logic             ser_msb,
   input  logic             ser_lsb,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] Q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       op, op_nxt;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             busy_nxt, done_nxt;
   logic             burst_op;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       code,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] ld,
      input logic             smsb,
      input logic             slsb
   );
      logic [WIDTH-1:0] r;
      case (code)
         3'b000:  r = cur;
         3'b001:  r = {smsb, cur[WIDTH-1:1]};
         3'b010:  r = {cur[WIDTH-2:0], slsb};
         3'b011:  r = ld;
         3'b100:  r = {cur[0], cur[WIDTH-1:1]};
         3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Only the shift/rotate codes make sense repeated; hold, load and clear stay single-step.
   assign burst_op = (control == 3'b001) || (control == 3'b010) || (control == 3'b100) ||
                     (control == 3'b101) || (control == 3'b110);

   assign sout_msb = Q[WIDTH-1];
   assign sout_lsb = Q[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         Q         <= '0;
         op        <= 3'b000;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (en) begin
         state     <= state_nxt;
         Q         <= q_nxt;
         op        <= op_nxt;
         remaining <= remaining_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      q_nxt         = Q;
      op_nxt        = op;
      remaining_nxt = remaining;
      case (state)
         IDLE: begin
            if (start && burst_op) begin
               op_nxt        = control;
               remaining_nxt = count;
               state_nxt     = (count == '0) ? DONE : RUN;
            end else begin
               q_nxt = apply_op(control, Q, data, ser_msb, ser_lsb);
            end
         end
         RUN: begin
            // Serial inputs are sampled live on every burst step.
            q_nxt         = apply_op(op, Q, data, ser_msb, ser_lsb);
            remaining_nxt = remaining - 1'b1;
            if (remaining <= 1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

endmodule

// File: tb/tb_param_univ_shift_register.sv
// Directed bench for param_univ_shift_register: expected Q/busy/done queued per edge, popped after it.
module tb_param_univ_shift_register;

   logic       clk = 1'b0;
   logic       reset, en, ser_msb, ser_lsb, start;
   logic [2:0] control;
   logic [7:0] data;
   logic [3:0] count;
   logic [7:0] Q;
   logic       sout_msb, sout_lsb, busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;
   exp_t sb[$];

   param_univ_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .control(control), .data(data),
      .ser_msb(ser_msb), .ser_lsb(ser_lsb), .start(start), .count(count),
      .Q(Q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_now(input string tag, input logic [7:0] q, input logic b, input logic d);
      chk({tag, ".Q"}, Q, q);
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
      chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
      chk({tag, ".sout_msb"}, {7'd0, sout_msb}, {7'd0, q[7]});
      chk({tag, ".sout_lsb"}, {7'd0, sout_lsb}, {7'd0, q[0]});
   endtask

   // Queue the expectation for the coming edge, then clock and compare against the popped entry.
   task automatic step(input string tag, input logic [7:0] q, input logic b, input logic d);
      exp_t e;
      sb.push_back('{tag: tag, q: q, busy: b, done: d});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_now(e.tag, e.q, e.busy, e.done);
   endtask

   task automatic drive(input logic [2:0] c, input logic [7:0] d, input logic s, input logic [3:0] n);
      control = c;
      data    = d;
      start   = s;
      count   = n;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; ser_msb = 1'b0; ser_lsb = 1'b0;
      drive(3'b000, 8'h00, 1'b0, 4'd0);

      // 1: reset while clocking, release, hold
      @(posedge clk); @(posedge clk); #1;
      check_now("reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      step("hold0", 8'h00, 1'b0, 1'b0);

      // 2: single-step ops
      drive(3'b011, 8'hA5, 1'b0, 4'd0); step("load_a5", 8'hA5, 1'b0, 1'b0);
      drive(3'b110, 8'h00, 1'b0, 4'd0); step("asr", 8'hD2, 1'b0, 1'b0);
      drive(3'b101, 8'h00, 1'b0, 4'd0); step("rol", 8'hA5, 1'b0, 1'b0);
      drive(3'b111, 8'h00, 1'b0, 4'd0); step("clear", 8'h00, 1'b0, 1'b0);
      ser_msb = 1'b1;
      drive(3'b001, 8'h00, 1'b0, 4'd0); step("shr_ser", 8'h80, 1'b0, 1'b0);
      ser_msb = 1'b0;
      drive(3'b000, 8'h00, 1'b1, 4'd5); step("start_hold", 8'h80, 1'b0, 1'b0);

      // 3: ROR burst of 3; control/data changes during RUN are ignored
      drive(3'b011, 8'h81, 1'b0, 4'd0); step("load_81", 8'h81, 1'b0, 1'b0);
      drive(3'b100, 8'h00, 1'b1, 4'd3); step("ror_acc", 8'h81, 1'b1, 1'b0);
      drive(3'b011, 8'hFF, 1'b1, 4'd9);
      step("ror_s1", 8'hC0, 1'b1, 1'b0);
      step("ror_s2", 8'h60, 1'b1, 1'b0);
      step("ror_s3", 8'h30, 1'b0, 1'b1);
      drive(3'b111, 8'h00, 1'b1, 4'd2); step("ror_done", 8'h30, 1'b0, 1'b0);

      // 4: SHL burst filling with ser_lsb, then a zero-length burst
      drive(3'b111, 8'h00, 1'b0, 4'd0); step("clr2", 8'h00, 1'b0, 1'b0);
      ser_lsb = 1'b1;
      drive(3'b010, 8'h00, 1'b1, 4'd4); step("shl_acc", 8'h00, 1'b1, 1'b0);
      drive(3'b000, 8'h00, 1'b0, 4'd0);
      step("shl_s1", 8'h01, 1'b1, 1'b0);
      step("shl_s2", 8'h03, 1'b1, 1'b0);
      step("shl_s3", 8'h07, 1'b1, 1'b0);
      step("shl_s4", 8'h0F, 1'b0, 1'b1);
      step("shl_idle", 8'h0F, 1'b0, 1'b0);
      drive(3'b010, 8'h00, 1'b1, 4'd0); step("cnt0_acc", 8'h0F, 1'b0, 1'b1);
      drive(3'b000, 8'h00, 1'b0, 4'd0); step("cnt0_idle", 8'h0F, 1'b0, 1'b0);
      ser_lsb = 1'b0;

      // 5: ROL burst frozen by en=0 for two cycles
      drive(3'b011, 8'h01, 1'b0, 4'd0); step("load_01", 8'h01, 1'b0, 1'b0);
      drive(3'b101, 8'h00, 1'b1, 4'd4); step("rol_acc", 8'h01, 1'b1, 1'b0);
      drive(3'b000, 8'h00, 1'b0, 4'd0);
      step("rol_s1", 8'h02, 1'b1, 1'b0);
      en = 1'b0;
      step("rol_frz1", 8'h02, 1'b1, 1'b0);
      step("rol_frz2", 8'h02, 1'b1, 1'b0);
      en = 1'b1;
      step("rol_s2", 8'h04, 1'b1, 1'b0);
      step("rol_s3", 8'h08, 1'b1, 1'b0);
      step("rol_s4", 8'h10, 1'b0, 1'b1);
      step("rol_idle", 8'h10, 1'b0, 1'b0);

      // 6: asynchronous reset mid-burst, then a fresh burst is accepted
      drive(3'b011, 8'h81, 1'b0, 4'd0); step("load_81b", 8'h81, 1'b0, 1'b0);
      drive(3'b100, 8'h00, 1'b1, 4'd5); step("ror5_acc", 8'h81, 1'b1, 1'b0);
      drive(3'b000, 8'h00, 1'b0, 4'd0);
      step("ror5_s1", 8'hC0, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1 check_now("midrst", 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_now("rst_held", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      drive(3'b011, 8'h03, 1'b0, 4'd0); step("load_03", 8'h03, 1'b0, 1'b0);
      drive(3'b100, 8'h00, 1'b1, 4'd1); step("ror1_acc", 8'h03, 1'b1, 1'b0);
      drive(3'b000, 8'h00, 1'b0, 4'd0);
      step("ror1_s1", 8'h81, 1'b0, 1'b1);
      step("ror1_idle", 8'h81, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
